alu_multicycle: RTL

Parametrised successor to the CPU's single-cycle 8-bit ALU/flag path. It executes logic, arithmetic, shift/rotate and an optional multi-cycle shift-add multiply on DATA_WIDTH operands. Results and the Z/N/C/V flags are registered behind a start/busy/done handshake. It sits between the A/B/temp registers and the control unit, which sequences microsteps from busy_o and done_o.

---
 rtl/arch_defs_pkg.sv | 26 ++
 rtl/alu_mul_seq.sv | 60 ++++++
 rtl/alu_multicycle.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/arch_defs_pkg.sv
// Shared operation codes and controller states for the multi-cycle ALU.
package arch_defs_pkg;

  typedef enum logic [3:0] {
    ALU_AND    = 4'd0,
    ALU_OR     = 4'd1,
    ALU_XOR    = 4'd2,
    ALU_ADD    = 4'd3,
    ALU_ADC    = 4'd4,
    ALU_SUB    = 4'd5,
    ALU_SBC    = 4'd6,
    ALU_INV    = 4'd7,
    ALU_SHL    = 4'd8,
    ALU_SHR    = 4'd9,
    ALU_ROL    = 4'd10,
    ALU_ROR    = 4'd11,
    ALU_MUL    = 4'd12,
    ALU_PASS_B = 4'd13
  } alu_op_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MUL_RUN = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier: one partial-product add per clock, DATA_WIDTH iterations.
module alu_mul_seq
  import arch_defs_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_load,
  input  logic [DATA_WIDTH-1:0]     i_a,
  input  logic [DATA_WIDTH-1:0]     i_b,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [2*DATA_WIDTH-1:0]   o_product_next
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_hi;
  logic [DATA_WIDTH-1:0] r_lo;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_busy;

  logic [DATA_WIDTH:0]   w_sum;
  logic                  w_last;

  // Multiplier bits drain out of r_lo as the product shifts in from the top.
  always_comb begin
    w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : {(DATA_WIDTH+1){1'b0}});
  end

  assign w_last         = r_busy && (r_cnt == CNT_W'(DATA_WIDTH-1));
  assign o_product_next = {w_sum, r_lo[DATA_WIDTH-1:1]};
  assign o_busy         = r_busy;
  assign o_done         = w_last;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_a    <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_load) begin
      r_a    <= i_a;
      r_hi   <= '0;
      r_lo   <= i_b;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      {r_hi, r_lo} <= o_product_next;
      r_cnt        <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Registered ALU with Z/N/C/V flags behind a start/busy/done handshake.
// Single-cycle ops complete on the start edge; MUL iterates in alu_mul_seq.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | accepting start_i; non-MUL ops write result on this edge
// ST_MUL_RUN | multiplier iterating; start_i ignored, busy_o high
module alu_multicycle
  import arch_defs_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ENABLE_MUL = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [3:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  carry_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic [DATA_WIDTH-1:0] result_hi_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  flag_zero_o,
  output logic                  flag_negative_o,
  output logic                  flag_carry_o,
  output logic                  flag_overflow_o
);

  localparam int MSB = DATA_WIDTH - 1;

  alu_state_t r_state;
  alu_state_t w_state_next;

  logic [DATA_WIDTH-1:0] r_result;
  logic [DATA_WIDTH-1:0] r_result_hi;
  logic                  r_done;
  logic                  r_flag_z;
  logic                  r_flag_n;
  logic                  r_flag_c;
  logic                  r_flag_v;

  logic                  w_is_mul;
  logic                  w_alu_wr;
  logic                  w_mul_load;
  logic                  w_mul_wr;
  logic                  w_mul_busy;
  logic                  w_mul_done;
  logic [2*DATA_WIDTH-1:0] w_mul_product;

  logic [DATA_WIDTH:0]   w_ext;
  logic [DATA_WIDTH-1:0] w_alu_res;
  logic                  w_alu_c;
  logic                  w_alu_v;
  logic                  w_alu_z;
  logic                  w_alu_n;

  assign w_is_mul = (ENABLE_MUL != 0) && (op_i == ALU_MUL);

  generate
    if (ENABLE_MUL != 0) begin : g_mul
      alu_mul_seq #(
        .DATA_WIDTH(DATA_WIDTH)
      ) u_mul_seq (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_load         (w_mul_load),
        .i_a            (a_i),
        .i_b            (b_i),
        .o_busy         (w_mul_busy),
        .o_done         (w_mul_done),
        .o_product_next (w_mul_product)
      );
    end else begin : g_no_mul
      assign w_mul_busy    = 1'b0;
      assign w_mul_done    = 1'b0;
      assign w_mul_product = '0;
    end
  endgenerate

  // Arithmetic is done one bit wider than the operands; the top bit is carry/borrow.
  always_comb begin
    w_ext     = '0;
    w_alu_res = b_i;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (op_i)
      ALU_AND: w_alu_res = a_i & b_i;
      ALU_OR:  w_alu_res = a_i | b_i;
      ALU_XOR: w_alu_res = a_i ^ b_i;
      ALU_INV: w_alu_res = ~a_i;
      ALU_ADD: begin
        w_ext     = {1'b0, a_i} + {1'b0, b_i};
        w_alu_res = w_ext[MSB:0];
        w_alu_c   = w_ext[DATA_WIDTH];
        w_alu_v   = (a_i[MSB] == b_i[MSB]) && (w_ext[MSB] != a_i[MSB]);
      end
      ALU_ADC: begin
        w_ext     = {1'b0, a_i} + {1'b0, b_i} + {{DATA_WIDTH{1'b0}}, carry_i};
        w_alu_res = w_ext[MSB:0];
        w_alu_c   = w_ext[DATA_WIDTH];
        w_alu_v   = (a_i[MSB] == b_i[MSB]) && (w_ext[MSB] != a_i[MSB]);
      end
      ALU_SUB: begin
        w_ext     = {1'b0, a_i} - {1'b0, b_i};
        w_alu_res = w_ext[MSB:0];
        w_alu_c   = w_ext[DATA_WIDTH];
        w_alu_v   = (a_i[MSB] != b_i[MSB]) && (w_ext[MSB] != a_i[MSB]);
      end
      ALU_SBC: begin
        w_ext     = {1'b0, a_i} - {1'b0, b_i} - {{DATA_WIDTH{1'b0}}, carry_i};
        w_alu_res = w_ext[MSB:0];
        w_alu_c   = w_ext[DATA_WIDTH];
        w_alu_v   = (a_i[MSB] != b_i[MSB]) && (w_ext[MSB] != a_i[MSB]);
      end
      ALU_SHL: begin
        w_alu_res = {a_i[MSB-1:0], 1'b0};
        w_alu_c   = a_i[MSB];
      end
      ALU_SHR: begin
        w_alu_res = {1'b0, a_i[MSB:1]};
        w_alu_c   = a_i[0];
      end
      ALU_ROL: begin
        w_alu_res = {a_i[MSB-1:0], carry_i};
        w_alu_c   = a_i[MSB];
      end
      ALU_ROR: begin
        w_alu_res = {carry_i, a_i[MSB:1]};
        w_alu_c   = a_i[0];
      end
      default: w_alu_res = b_i;
    endcase
  end

  assign w_alu_z = (w_alu_res == '0);
  assign w_alu_n = w_alu_res[MSB];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_alu_wr     = 1'b0;
    w_mul_load   = 1'b0;
    w_mul_wr     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          if (w_is_mul) begin
            w_mul_load   = 1'b1;
            w_state_next = ST_MUL_RUN;
          end else begin
            w_alu_wr = 1'b1;
          end
        end
      end
      ST_MUL_RUN: begin
        if (w_mul_done) begin
          w_mul_wr     = 1'b1;
          w_state_next = ST_IDLE;
        end else if (!w_mul_busy) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_result    <= '0;
      r_result_hi <= '0;
      r_done      <= 1'b0;
      r_flag_z    <= 1'b0;
      r_flag_n    <= 1'b0;
      r_flag_c    <= 1'b0;
      r_flag_v    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_alu_wr) begin
        r_result    <= w_alu_res;
        r_result_hi <= '0;
        r_flag_z    <= w_alu_z;
        r_flag_n    <= w_alu_n;
        r_flag_c    <= w_alu_c;
        r_flag_v    <= w_alu_v;
        r_done      <= 1'b1;
      end else if (w_mul_wr) begin
        // Z spans the full double-width product; N comes from the high half.
        r_result    <= w_mul_product[DATA_WIDTH-1:0];
        r_result_hi <= w_mul_product[2*DATA_WIDTH-1:DATA_WIDTH];
        r_flag_z    <= (w_mul_product == '0);
        r_flag_n    <= w_mul_product[2*DATA_WIDTH-1];
        r_flag_c    <= (w_mul_product[2*DATA_WIDTH-1:DATA_WIDTH] != '0);
        r_flag_v    <= 1'b0;
        r_done      <= 1'b1;
      end
    end
  end

  assign result_o        = r_result;
  assign result_hi_o     = r_result_hi;
  assign busy_o          = (r_state == ST_MUL_RUN);
  assign done_o          = r_done;
  assign flag_zero_o     = r_flag_z;
  assign flag_negative_o = r_flag_n;
  assign flag_carry_o    = r_flag_c;
  assign flag_overflow_o = r_flag_v;

endmodule
